lmsm_sequencer: RTL and testbench

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

---
 rtl/lmsm_pkg.sv | 26 ++
 rtl/lmsm_prienc.sv | 22 ++
 rtl/lmsm_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lmsm_pkg.sv
// Shared constants and types for the LM/SM micro-op sequencer.
// LMSM_SKIP_ZERO_EN (in lmsm_sequencer) selects skip-zero issue instead of the 8-slot walk.
package lmsm_pkg;

    localparam int MASK_W = 8;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;
    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    // Instruction mask bit (7-k) names Rk; returns the mask with bit k = Rk.
    function automatic logic [MASK_W-1:0] to_reg_order(input logic [MASK_W-1:0] m);
        logic [MASK_W-1:0] r;
        for (int k = 0; k < MASK_W; k++) begin
            r[k] = m[MASK_W-1-k];
        end
        return r;
    endfunction

endpackage

// File: rtl/lmsm_prienc.sv
// 8-bit priority encoder: index of the lowest set request bit, plus an any-set flag.
module lmsm_prienc
    import lmsm_pkg::*;
(
    input  logic [MASK_W-1:0] req,
    output logic [2:0]        index,
    output logic              any
);

    always_comb begin
        index = 3'd0;
        any   = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = 3'(i);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM in ID into a stream of LW/SW micro-ops injected at the ID2RR input.
// Define LMSM_SKIP_ZERO_EN to issue only set mask bits; otherwise slots walk R0..R7 in order.
module lmsm_sequencer
    import lmsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr_in,
    input  logic        downstream_stall,
    input  logic        flush,
    output logic        id_stall,
    output logic        uop_valid,
    output logic [15:0] uop_instr,
    output logic        uop_last,
    output logic        busy
);

    state_t            state_q, state_d;
    logic [MASK_W-1:0] mask_q, mask_d;     // registers not yet presented, bit k = Rk
    logic [2:0]        ra_q, ra_d;
    logic              is_sm_q, is_sm_d;
    logic [2:0]        count_q, count_d;   // uops issued so far, becomes imm6
    logic              uop_valid_q, uop_valid_d;
    logic              uop_last_q, uop_last_d;
    logic [15:0]       uop_instr_q, uop_instr_d;
`ifndef LMSM_SKIP_ZERO_EN
    logic [2:0]        pos_q, pos_d;
    logic [2:0]        src_pos;
`endif

    logic              detect;
    logic [MASK_W-1:0] src_mask, rem_mask;
    logic [2:0]        src_ra, src_count;
    logic              src_sm;
    logic [2:0]        pe_idx;
    logic              pe_any;
    logic              slot_valid, slot_last;
    logic [15:0]       slot_instr;
    logic              unused_instr_bit;

    assign unused_instr_bit = instr_in[8];

    assign detect = instr_valid
                  && (instr_in[15:12] == OP_LM || instr_in[15:12] == OP_SM)
                  && (instr_in[7:0] != 8'h00);

    // The next slot is built from the incoming instruction in IDLE, from latched state in SEQ.
    always_comb begin
        if (state_q == ST_IDLE) begin
            src_mask  = to_reg_order(instr_in[7:0]);
            src_ra    = instr_in[11:9];
            src_sm    = (instr_in[15:12] == OP_SM);
            src_count = 3'd0;
        end else begin
            src_mask  = mask_q;
            src_ra    = ra_q;
            src_sm    = is_sm_q;
            src_count = count_q;
        end
    end

`ifndef LMSM_SKIP_ZERO_EN
    assign src_pos = (state_q == ST_IDLE) ? 3'd0 : pos_q;
`endif

    lmsm_prienc u_prienc (
        .req   (src_mask),
        .index (pe_idx),
        .any   (pe_any)
    );

    always_comb begin
`ifdef LMSM_SKIP_ZERO_EN
        slot_valid = pe_any;
`else
        // Pending bits below the walk position are already cleared, so a match means bit pos is set.
        slot_valid = pe_any && (pe_idx == src_pos);
`endif
        rem_mask   = src_mask;
        slot_instr = 16'h0000;
        if (slot_valid) begin
            rem_mask   = src_mask & ~(MASK_W'(1) << pe_idx);
            slot_instr = {(src_sm ? OP_SW : OP_LW), pe_idx, src_ra, {3'b000, src_count}};
        end
        slot_last = slot_valid && (rem_mask == '0);
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ra_d        = ra_q;
        is_sm_d     = is_sm_q;
        count_d     = count_q;
        uop_valid_d = uop_valid_q;
        uop_last_d  = uop_last_q;
        uop_instr_d = uop_instr_q;
`ifndef LMSM_SKIP_ZERO_EN
        pos_d       = pos_q;
`endif
        id_stall    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (detect && !flush) begin
                    id_stall    = 1'b1;
                    state_d     = ST_SEQ;
                    mask_d      = rem_mask;
                    ra_d        = src_ra;
                    is_sm_d     = src_sm;
                    count_d     = {2'b00, slot_valid};
                    uop_valid_d = slot_valid;
                    uop_last_d  = slot_last;
                    uop_instr_d = slot_instr;
`ifndef LMSM_SKIP_ZERO_EN
                    pos_d       = 3'd1;
`endif
                end
            end
            ST_SEQ: begin
                if (flush || (uop_last_q && !downstream_stall)) begin
                    // The last uop leaves at this edge with ID released alongside it.
                    state_d     = ST_IDLE;
                    mask_d      = '0;
                    count_d     = 3'd0;
                    uop_valid_d = 1'b0;
                    uop_last_d  = 1'b0;
                    uop_instr_d = 16'h0000;
`ifndef LMSM_SKIP_ZERO_EN
                    pos_d       = 3'd0;
`endif
                    id_stall    = 1'b0;
                end else if (downstream_stall) begin
                    id_stall = 1'b1;
                end else begin
                    id_stall    = 1'b1;
                    mask_d      = rem_mask;
                    count_d     = count_q + {2'b00, slot_valid};
                    uop_valid_d = slot_valid;
                    uop_last_d  = slot_last;
                    uop_instr_d = slot_instr;
`ifndef LMSM_SKIP_ZERO_EN
                    pos_d       = pos_q + 3'd1;
`endif
                end
                if (uop_last_q && !downstream_stall) begin
                    id_stall = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            ra_q        <= 3'd0;
            is_sm_q     <= 1'b0;
            count_q     <= 3'd0;
            uop_valid_q <= 1'b0;
            uop_last_q  <= 1'b0;
            uop_instr_q <= 16'h0000;
`ifndef LMSM_SKIP_ZERO_EN
            pos_q       <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ra_q        <= ra_d;
            is_sm_q     <= is_sm_d;
            count_q     <= count_d;
            uop_valid_q <= uop_valid_d;
            uop_last_q  <= uop_last_d;
            uop_instr_q <= uop_instr_d;
`ifndef LMSM_SKIP_ZERO_EN
            pos_q       <= pos_d;
`endif
        end
    end

    // A flush kills the uop on offer in the same cycle.
    assign uop_valid = uop_valid_q && !flush;
    assign uop_last  = uop_last_q && !flush;
    assign uop_instr = uop_instr_q;
    assign busy      = (state_q == ST_SEQ);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: directed LM/SM cases plus randomized instruction streams.
// Handshake: a uop enters ID2RR on a cycle with uop_valid=1 and downstream_stall=0; while stalled it is held.
module tb_lmsm_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr_in;
    logic        downstream_stall;
    logic        flush;
    logic        id_stall;
    logic        uop_valid;
    logic [15:0] uop_instr;
    logic        uop_last;
    logic        busy;

    logic [16:0] exp_q[$];   // {uop_last, uop_instr}
    int          total;
    int          bad;

    lmsm_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .instr_valid      (instr_valid),
        .instr_in         (instr_in),
        .downstream_stall (downstream_stall),
        .flush            (flush),
        .id_stall         (id_stall),
        .uop_valid        (uop_valid),
        .uop_instr        (uop_instr),
        .uop_last         (uop_last),
        .busy             (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every offered uop must match the queue front; it is consumed when not stalled.
    always @(negedge clk) begin
        if (!rst && uop_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mon_unexpected: got %h want no uop", uop_instr);
            end else begin
                if ({uop_last, uop_instr} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL mon_uop: got last=%b instr=%h want last=%b instr=%h",
                             uop_last, uop_instr, exp_q[0][16], exp_q[0][15:0]);
                end
                if (!downstream_stall) void'(exp_q.pop_front());
            end
        end
    end

    // Drives one instruction through ID and checks the cycle-level handshake.
    task automatic run_seq(input logic [15:0] ins, input int stall_pct, input int first_stall,
                           input int flush_slot, input int rst_slot);
        logic [3:0]  op;
        logic [7:0]  m;
        bit          seq;
        int          slot_rd[$];
        bit          slot_ok[$];
        int          last_k;
        int          issued;
        int          n_slots;
        logic [15:0] u;

        op = ins[15:12];
        m  = ins[7:0];
        seq = (op == 4'b0110 || op == 4'b0111) && (m != 8'h00);

        @(posedge clk); #1;
        instr_valid      = 1'b1;
        instr_in         = ins;
        flush            = 1'b0;
        downstream_stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("detect_id_stall", 16'(id_stall), 16'(seq));
        check("detect_uop_valid", 16'(uop_valid), 16'h0);

        if (!seq) begin
            @(posedge clk); #1;
            instr_valid      = 1'b0;
            downstream_stall = 1'b0;
            @(negedge clk);
            check("pass_busy", 16'(busy), 16'h0);
            check("pass_id_stall", 16'(id_stall), 16'h0);
            return;
        end

        // Reference issue schedule: register k lives in mask bit 7-k, R0 first.
        last_k = -1;
        for (int k = 0; k < 8; k++) if (m[7-k]) last_k = k;
`ifdef LMSM_SKIP_ZERO_EN
        for (int k = 0; k < 8; k++) begin
            if (m[7-k]) begin
                slot_rd.push_back(k);
                slot_ok.push_back(1'b1);
            end
        end
`else
        for (int k = 0; k <= last_k; k++) begin
            slot_rd.push_back(k);
            slot_ok.push_back(m[7-k]);
        end
`endif
        n_slots = slot_rd.size();
        issued  = 0;

        for (int s = 0; s < n_slots; s++) begin
            bit last_s;
            int n_st;
            last_s = (s == n_slots - 1);
            if (s == 0) n_st = first_stall;
            else n_st = ($urandom_range(0, 99) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
            if (s == flush_slot || s == rst_slot) n_st = 0;

            for (int c = 0; c <= n_st; c++) begin
                @(posedge clk); #1;
                downstream_stall = (c < n_st);
                flush            = (s == flush_slot);
                rst              = (s == rst_slot);
                if (flush) downstream_stall = 1'($urandom_range(0, 1));
                if (c == 0 && slot_ok[s] && !flush && !rst) begin
                    u = {(op == 4'b0111) ? 4'b0101 : 4'b0100, 3'(slot_rd[s]), ins[11:9], 6'(issued)};
                    exp_q.push_back({last_s, u});
                    issued++;
                end
                @(negedge clk);
                if (flush) begin
                    check("flush_uop_valid", 16'(uop_valid), 16'h0);
                    check("flush_id_stall", 16'(id_stall), 16'h0);
                end else if (!rst) begin
                    check("seq_busy", 16'(busy), 16'h1);
                    check("seq_uop_valid", 16'(uop_valid), 16'(slot_ok[s]));
                    check("seq_id_stall", 16'(id_stall), 16'((c < n_st) || !last_s));
                end
            end

            if (s == flush_slot) begin
                @(posedge clk); #1;
                flush            = 1'b0;
                downstream_stall = 1'b0;
                instr_valid      = 1'b1;
                instr_in         = 16'h1234;
                @(negedge clk);
                check("post_flush_busy", 16'(busy), 16'h0);
                check("post_flush_id_stall", 16'(id_stall), 16'h0);
                check("post_flush_uop_valid", 16'(uop_valid), 16'h0);
                return;
            end
            if (s == rst_slot) begin
                @(posedge clk); #1;
                rst              = 1'b0;
                instr_valid      = 1'b0;
                downstream_stall = 1'b0;
                @(negedge clk);
                check("rst_busy", 16'(busy), 16'h0);
                check("rst_uop_valid", 16'(uop_valid), 16'h0);
                check("rst_uop_last", 16'(uop_last), 16'h0);
                check("rst_uop_instr", uop_instr, 16'h0000);
                check("rst_id_stall", 16'(id_stall), 16'h0);
                return;
            end
        end

        @(posedge clk); #1;
        instr_valid      = 1'b0;
        downstream_stall = 1'b0;
        @(negedge clk);
        check("end_busy", 16'(busy), 16'h0);
        check("end_uop_valid", 16'(uop_valid), 16'h0);
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op;
        int          pick;

        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        instr_valid      = 1'b0;
        instr_in         = 16'h0000;
        downstream_stall = 1'b0;
        flush            = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_uop_valid", 16'(uop_valid), 16'h0);
        check("reset_uop_instr", uop_instr, 16'h0000);
        check("reset_id_stall", 16'(id_stall), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_seq(16'h62A0, 0, 0, -1, -1);   // LM R1 base, R0 and R2
        run_seq(16'h74FF, 0, 0, -1, -1);   // SM all registers
        run_seq(16'h62A0, 0, 3, -1, -1);   // first uop held by downstream stall
        run_seq(16'h62E0, 0, 0, 1, -1);    // flush on the second uop
        run_seq(16'h6200, 0, 0, -1, -1);   // empty mask passes as NOP
        run_seq(16'h76FF, 0, 0, -1, 3);    // reset mid-sequence
        run_seq(16'h6201, 0, 0, -1, -1);   // only R7

        for (int i = 0; i < 40; i++) begin
            pick = int'($urandom_range(0, 3));
            op   = ($urandom_range(0, 1) != 0) ? 4'b0111 : 4'b0110;
            if (pick == 2) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'b0110 || op == 4'b0111) op = 4'b0001;
            end
            ins = {op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255))};
            if (pick == 3) ins[7:0] = 8'h00;
            run_seq(ins, 25, ($urandom_range(0, 3) == 0) ? 2 : 0, -1, -1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
